// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - CSR numbers, CSR operations and CSR access arbiter state encoding
package ibex_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS  = 12'h300,
    CSR_MISA     = 12'h301,
    CSR_MIE      = 12'h304,
    CSR_MTVEC    = 12'h305,
    CSR_MSCRATCH = 12'h340,
    CSR_MEPC     = 12'h341,
    CSR_MCAUSE   = 12'h342,
    CSR_MTVAL    = 12'h343,
    CSR_MIP      = 12'h344,
    CSR_MHARTID  = 12'hF14
  } csr_num_e;

  typedef enum logic [1:0] {
    CSR_OP_READ,
    CSR_OP_WRITE,
    CSR_OP_SET,
    CSR_OP_CLEAR
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RMW_WR,
    RESP
  } csr_arb_state_e;

endpackage

// File: rtl/ibex_csr_rr_arb.sv
// rtl/ibex_csr_rr_arb.sv - combinational round-robin picker: first request at or after ptr, cyclically
module ibex_csr_rr_arb #(
  parameter int N    = 2,
  parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            valid
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      int c;
      c = int'(ptr) + off;
      if (c >= N) c = c - N;
      if (req[c]) begin
        gnt    = '0;
        gnt[c] = 1'b1;
        idx    = IdxW'(c);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ibex_csr_access_arb.sv
// rtl/ibex_csr_access_arb.sv - round-robin CSR port arbiter with SET/CLEAR as read-modify-write; IBEX_CSR_ARB_ERR_EN enables illegal-access error reporting
module ibex_csr_access_arb
  import ibex_pkg::*;
#(
  parameter int NumReq    = 2,
  parameter int DataWidth = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq*12-1:0]        req_addr_i,
  input  logic [NumReq*2-1:0]         req_op_i,
  input  logic [NumReq*DataWidth-1:0] req_wdata_i,
  output logic [NumReq-1:0]           gnt_o,
  output logic [NumReq-1:0]           rvalid_o,
  output logic [DataWidth-1:0]        rdata_o,
  output logic                        err_o,
  output logic                        csr_access_o,
  output logic [11:0]                 csr_addr_o,
  output logic [1:0]                  csr_op_o,
  output logic [DataWidth-1:0]        csr_wdata_o,
  input  logic [DataWidth-1:0]        csr_rdata_i,
  input  logic                        csr_illegal_i
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  csr_arb_state_e       state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_d, idx_q, idx_d;
  csr_num_e             addr_q, addr_d;
  csr_op_e              op_q, op_d;
  logic [DataWidth-1:0] wdata_q, wdata_d, old_q, old_d;
  logic                 err_q, err_d;

  logic [NumReq-1:0]    pick_gnt;
  logic [IdxW-1:0]      pick_idx, ptr_next;
  logic                 pick_valid;
  csr_num_e             sel_addr;
  csr_op_e              sel_op;
  logic [DataWidth-1:0] sel_wdata;
  logic                 illegal;

`ifdef IBEX_CSR_ARB_ERR_EN
  assign illegal = csr_illegal_i;
`else
  logic unused_csr_illegal;
  assign unused_csr_illegal = csr_illegal_i;
  assign illegal            = 1'b0;
`endif

  ibex_csr_rr_arb #(
    .N    (NumReq),
    .IdxW (IdxW)
  ) u_rr_arb (
    .req   (req_i),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign sel_addr  = csr_num_e'(req_addr_i[int'(pick_idx)*12 +: 12]);
  assign sel_op    = csr_op_e'(req_op_i[int'(pick_idx)*2 +: 2]);
  assign sel_wdata = req_wdata_i[int'(pick_idx)*DataWidth +: DataWidth];
  assign ptr_next  = (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + 1'b1;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    op_d         = op_q;
    wdata_d      = wdata_q;
    old_d        = old_q;
    err_d        = err_q;
    gnt_o        = '0;
    rvalid_o     = '0;
    rdata_o      = '0;
    err_o        = 1'b0;
    csr_access_o = 1'b0;
    csr_addr_o   = '0;
    csr_op_o     = CSR_OP_READ;
    csr_wdata_o  = '0;
    unique case (state_q)
      IDLE: begin
        // Gated by reset so nothing reaches the port while reset is held.
        if (rst_ni && pick_valid) begin
          gnt_o        = pick_gnt;
          csr_access_o = 1'b1;
          csr_addr_o   = sel_addr;
          idx_d        = pick_idx;
          ptr_d        = ptr_next;
          addr_d       = sel_addr;
          op_d         = sel_op;
          wdata_d      = sel_wdata;
          old_d        = csr_rdata_i;
          err_d        = illegal;
          if (sel_op == CSR_OP_WRITE) begin
            csr_op_o    = CSR_OP_WRITE;
            csr_wdata_o = sel_wdata;
            state_d     = RESP;
          end else if (sel_op == CSR_OP_READ || illegal) begin
            state_d = RESP;
          end else begin
            state_d = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        csr_access_o = 1'b1;
        csr_addr_o   = addr_q;
        csr_op_o     = CSR_OP_WRITE;
        csr_wdata_o  = (op_q == CSR_OP_SET) ? (old_q | wdata_q) : (old_q & ~wdata_q);
        err_d        = err_q | illegal;
        state_d      = RESP;
      end
      RESP: begin
        rvalid_o = NumReq'(1) << idx_q;
        rdata_o  = err_q ? '0 : old_q;
        err_o    = err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      addr_q  <= CSR_MSTATUS;
      op_q    <= CSR_OP_READ;
      wdata_q <= '0;
      old_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ibex_csr_access_arb.sv
// tb/tb_ibex_csr_access_arb.sv - self-checking bench for ibex_csr_access_arb against a transaction-level model
module tb_ibex_csr_access_arb;
  import ibex_pkg::*;

  localparam int N  = 3;
  localparam int DW = 32;

`ifdef IBEX_CSR_ARB_ERR_EN
  localparam bit Feat = 1'b1;
`else
  localparam bit Feat = 1'b0;
`endif

  logic            clk;
  logic            rst_ni;
  logic [N-1:0]    req_i;
  logic [N*12-1:0] req_addr_i;
  logic [N*2-1:0]  req_op_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic            err_o;
  logic            csr_access_o;
  logic [11:0]     csr_addr_o;
  logic [1:0]      csr_op_o;
  logic [DW-1:0]   csr_wdata_o;
  logic [DW-1:0]   csr_rdata_i;
  logic            csr_illegal_i;

  ibex_csr_access_arb #(.NumReq(N), .DataWidth(DW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .req_addr_i    (req_addr_i),
    .req_op_i      (req_op_i),
    .req_wdata_i   (req_wdata_i),
    .gnt_o         (gnt_o),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .err_o         (err_o),
    .csr_access_o  (csr_access_o),
    .csr_addr_o    (csr_addr_o),
    .csr_op_o      (csr_op_o),
    .csr_wdata_o   (csr_wdata_o),
    .csr_rdata_i   (csr_rdata_i),
    .csr_illegal_i (csr_illegal_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file behind the port: combinational read, write on clock, 0xF14 read-only/illegal.
  logic [DW-1:0] rf [4096];
  logic          pl_en;
  logic [11:0]   pl_addr;
  logic [DW-1:0] pl_data;

  assign csr_rdata_i   = rf[csr_addr_o];
  assign csr_illegal_i = csr_access_o && (csr_addr_o == 12'hF14);

  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (csr_access_o && csr_op_o == 2'd1 && !csr_illegal_i) rf[csr_addr_o] <= csr_wdata_o;
  end

  // Reference model state
  logic [DW-1:0] ref_mem [4096];
  int            ptr_m;
  logic [N-1:0]  pend;
  logic [11:0]   p_addr [N];
  logic [1:0]    p_op [N];
  logic [DW-1:0] p_wd [N];
  logic [11:0]   addr_tab [5];

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_i = pend;
    for (int i = 0; i < N; i++) begin
      req_addr_i[i*12 +: 12]  = p_addr[i];
      req_op_i[i*2 +: 2]      = p_op[i];
      req_wdata_i[i*DW +: DW] = p_wd[i];
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic add(input int i, input logic [1:0] op, input logic [11:0] a, input logic [DW-1:0] wd);
    if (!pend[i]) begin
      p_op[i] = op; p_addr[i] = a; p_wd[i] = wd;
      pend[i] = 1'b1;
    end
  endtask

  function automatic int pick();
    for (int off = 0; off < N; off++)
      if (pend[(ptr_m + off) % N]) return (ptr_m + off) % N;
    return -1;
  endfunction

  // One arbitration round: grant beat, optional write beat, response beat.
  task automatic txn();
    int            w;
    logic [11:0]   a;
    logic [1:0]    op;
    logic [DW-1:0] wd, old, nv;
    logic          ill, rmw;
    drive(); #1;
    w = pick();
    if (w < 0) begin
      chk("idle_gnt", 64'(gnt_o), 64'd0);
      chk("idle_access", 64'(csr_access_o), 64'd0);
      @(posedge clk); #1;
      return;
    end
    a = p_addr[w]; op = p_op[w]; wd = p_wd[w];
    old = ref_mem[a];
    ill = (a == 12'hF14);
    rmw = (op == 2'd2) || (op == 2'd3);
    nv  = (op == 2'd1) ? wd : (op == 2'd2) ? (old | wd) : (old & ~wd);
    chk("gnt", 64'(gnt_o), 64'd1 << w);
    chk("beat0_access", 64'(csr_access_o), 64'd1);
    chk("beat0_addr", 64'(csr_addr_o), 64'(a));
    chk("beat0_op", 64'(csr_op_o), (op == 2'd1) ? 64'd1 : 64'd0);
    if (op == 2'd1) chk("beat0_wdata", 64'(csr_wdata_o), 64'(wd));
    @(posedge clk); #1;
    pend[w] = 1'b0;
    drive(); #1;
    if (rmw && !(Feat && ill)) begin
      chk("beat1_access", 64'(csr_access_o), 64'd1);
      chk("beat1_op", 64'(csr_op_o), 64'd1);
      chk("beat1_addr", 64'(csr_addr_o), 64'(a));
      chk("beat1_wdata", 64'(csr_wdata_o), 64'(nv));
      chk("beat1_gnt", 64'(gnt_o), 64'd0);
      @(posedge clk); #2;
    end
    chk("resp_rvalid", 64'(rvalid_o), 64'd1 << w);
    chk("resp_rdata", 64'(rdata_o), (Feat && ill) ? 64'd0 : 64'(old));
    chk("resp_err", 64'(err_o), 64'(Feat && ill));
    chk("resp_gnt", 64'(gnt_o), 64'd0);
    chk("resp_access", 64'(csr_access_o), 64'd0);
    if (op != 2'd0 && !ill) ref_mem[a] = nv;
    ptr_m = (w + 1) % N;
    @(posedge clk); #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    ptr_m = 0; pend = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    addr_tab[0] = 12'h300; addr_tab[1] = 12'h304; addr_tab[2] = 12'h344;
    addr_tab[3] = 12'h340; addr_tab[4] = 12'hF14;
    for (int i = 0; i < N; i++) begin p_addr[i] = '0; p_op[i] = '0; p_wd[i] = '0; end
    rst_ni = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_access", 64'(csr_access_o), 64'd0);
    chk("rst_rdata", 64'(rdata_o), 64'd0);
    rst_ni = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) preload(addr_tab[i], $urandom);

    // Directed: read, set, clear
    preload(12'h300, 32'h1888);
    add(0, 2'd0, 12'h300, 32'h0); txn();
    preload(12'h304, 32'h08);
    add(1, 2'd2, 12'h304, 32'h80); txn();
    preload(12'h344, 32'hFF);
    add(0, 2'd3, 12'h344, 32'h0F); txn();
    add(2, 2'd0, 12'h344, 32'h0); txn();

    // Two requesters held continuously
    for (int k = 0; k < 6; k++) begin
      add(0, 2'd0, 12'h300, 32'h0);
      add(1, 2'd0, 12'h304, 32'h0);
      txn();
    end
    while (pend != 0) txn();
    txn();

    // Random traffic
    for (int k = 0; k < 150; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 1) == 1)
          add(i, 2'($urandom_range(0, 3)), addr_tab[$urandom_range(0, 4)], $urandom);
      txn();
    end
    while (pend != 0) txn();

    // Reset during the write beat of a SET
    add(1, 2'd2, 12'h340, 32'hFFFF_0000);
    drive(); #1;
    chk("rmwrst_gnt", 64'(gnt_o), 64'd1 << pick());
    @(posedge clk); #1;
    rst_ni = 1'b0;
    pend = '0; drive(); #1;
    chk("rmwrst_access", 64'(csr_access_o), 64'd0);
    chk("rmwrst_rvalid", 64'(rvalid_o), 64'd0);
    @(posedge clk); #1;
    chk("rmwrst_rvalid2", 64'(rvalid_o), 64'd0);
    chk("rmwrst_access2", 64'(csr_access_o), 64'd0);
    rst_ni = 1'b1; ptr_m = 0; #1;
    chk("post_rst_outs", {gnt_o, rvalid_o, err_o, csr_access_o, csr_op_o}, 64'd0);
    chk("post_rst_data", {rdata_o, csr_wdata_o}, 64'd0);
    add(0, 2'd0, 12'h300, 32'h0);
    add(1, 2'd0, 12'h340, 32'h0);
    add(2, 2'd0, 12'h304, 32'h0);
    while (pend != 0) txn();

    // Illegal target: SET, WRITE and READ
    preload(12'hF14, 32'h55);
    add(0, 2'd2, 12'hF14, 32'hF0); txn();
    add(2, 2'd1, 12'hF14, 32'h1234); txn();
    add(1, 2'd0, 12'hF14, 32'h0); txn();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
